// File: rtl/ad9833_sweep_ctrl_if.sv
// Request/ack/complete bundle between the sweep sequencer and the ad9833 serial driver.
// Latency: none, plain wires.
// Backpressure: the driver paces each frame with good_to_reset_go and send_complete.
interface ad9833_sweep_ctrl_if;
  logic        go;
  logic [15:0] control;
  logic [27:0] freq;
  logic        good_to_reset_go;
  logic        send_complete;

  modport master (
    output go,
    output control,
    output freq,
    input  good_to_reset_go,
    input  send_complete
  );

  modport slave (
    input  go,
    input  control,
    input  freq,
    output good_to_reset_go,
    output send_complete
  );
endinterface

// File: rtl/ad9833_sweep_ctrl.sv
// Frequency-sweep sequencer for the ad9833 driver: one RST frame, N RUN frames, one MUTE frame.
// Latency: start -> go in 1 cycle; send_complete -> next go in 1 cycle, or 1+dwell after a RUN frame.
// Backpressure: each frame waits indefinitely for the driver's ack and completion.
module ad9833_sweep_ctrl #(
  parameter int DWELL_W = 24,
  parameter int PTS_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [27:0]         cfg_start_freq,
  input  logic [27:0]         cfg_step,
  input  logic                cfg_down,
  input  logic [PTS_W-1:0]    cfg_points,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  input  logic [1:0]          cfg_wave,
  ad9833_sweep_ctrl_if.master drv,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [PTS_W-1:0]    point_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ACK_WAIT, S_CPL_WAIT, S_DWELL, S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    FR_RST, FR_RUN, FR_MUTE
  } frame_t;

  // RESET bit of the ad9833 control word, used by both the load and mute frames
  localparam logic [15:0] RESET_BIT = 16'h0100;

  function automatic logic [15:0] wave_bits(input logic [1:0] w);
    case (w)
      2'd0:    wave_bits = 16'h2000;
      2'd1:    wave_bits = 16'h2002;
      default: wave_bits = 16'h2028;
    endcase
  endfunction

  state_t             state_q;
  frame_t             frame_q;
  logic               go_q;
  logic [15:0]        ctrl_q;
  logic [27:0]        freq_q;      // doubles as the sweep accumulator
  logic               busy_q;
  logic               done_q;
  logic               aborted_q;
  logic [PTS_W-1:0]   idx_q;
  logic [27:0]        step_q;
  logic               down_q;
  logic [PTS_W-1:0]   pts_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [15:0]        wave_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic               abort_q;     // abort seen during a non-mute frame or dwell
  logic               cpl_pend_q;  // completion arrived together with the ack

  logic               cpl_seen_d;
  logic               abort_any_d;
  logic               last_pt_d;
  logic [27:0]        run_freq_d;
  logic               adv_d;
  logic               to_mute_d;

  assign cpl_seen_d  = drv.send_complete | cpl_pend_q;
  assign abort_any_d = abort | abort_q;
  assign last_pt_d   = ((idx_q + PTS_W'(1)) == pts_q);
  assign run_freq_d  = down_q ? (freq_q - step_q) : (freq_q + step_q);

  // Decide when the RUN sequence moves on (end of dwell, zero dwell, or abort) and whether to mute
  always_comb begin
    adv_d     = 1'b0;
    to_mute_d = abort_any_d | last_pt_d;
    case (state_q)
      S_CPL_WAIT: adv_d = cpl_seen_d && (frame_q == FR_RUN) &&
                          ((dwell_q == '0) || abort_any_d);
      S_DWELL:    adv_d = abort || (dwell_cnt_q <= DWELL_W'(1));
      default:    adv_d = 1'b0;
    endcase
  end

  // Sweep state machine with registered driver-facing and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      frame_q     <= FR_RST;
      go_q        <= 1'b0;
      ctrl_q      <= 16'h0000;
      freq_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      idx_q       <= '0;
      step_q      <= '0;
      down_q      <= 1'b0;
      pts_q       <= '0;
      dwell_q     <= '0;
      wave_q      <= 16'h0000;
      dwell_cnt_q <= '0;
      abort_q     <= 1'b0;
      cpl_pend_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;

      // An abort during the mute frame itself is not recorded
      if (abort && (frame_q != FR_MUTE) &&
          (state_q inside {S_REQ, S_ACK_WAIT, S_CPL_WAIT, S_DWELL}))
        abort_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            step_q     <= cfg_step;
            down_q     <= cfg_down;
            pts_q      <= cfg_points;
            dwell_q    <= cfg_dwell;
            wave_q     <= wave_bits(cfg_wave);
            freq_q     <= cfg_start_freq;
            ctrl_q     <= wave_bits(cfg_wave) | RESET_BIT;
            frame_q    <= FR_RST;
            idx_q      <= '0;
            abort_q    <= 1'b0;
            cpl_pend_q <= 1'b0;
            go_q       <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_REQ;
          end
        end

        S_REQ: state_q <= S_ACK_WAIT;

        S_ACK_WAIT: begin
          if (drv.good_to_reset_go) begin
            go_q       <= 1'b0;
            cpl_pend_q <= drv.send_complete;
            state_q    <= S_CPL_WAIT;
          end
        end

        S_CPL_WAIT: begin
          if (cpl_seen_d) begin
            cpl_pend_q <= 1'b0;
            case (frame_q)
              FR_RST: begin
                go_q    <= 1'b1;
                state_q <= S_REQ;
                if (abort_any_d || (pts_q == '0)) begin
                  frame_q <= FR_MUTE;
                  ctrl_q  <= wave_q | RESET_BIT;
                end else begin
                  frame_q <= FR_RUN;
                  ctrl_q  <= wave_q;
                  idx_q   <= '0;
                end
              end
              FR_RUN: begin
                if (!adv_d) begin
                  dwell_cnt_q <= dwell_q;
                  state_q     <= S_DWELL;
                end
              end
              default: begin
                done_q    <= 1'b1;
                aborted_q <= abort_q;
                busy_q    <= 1'b0;
                state_q   <= S_FINISH;
              end
            endcase
          end
        end

        S_DWELL: dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);

        S_FINISH: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase

      // Launch the next RUN point or the closing mute frame
      if (adv_d) begin
        go_q    <= 1'b1;
        state_q <= S_REQ;
        if (to_mute_d) begin
          frame_q <= FR_MUTE;
          ctrl_q  <= wave_q | RESET_BIT;
        end else begin
          frame_q <= FR_RUN;
          ctrl_q  <= wave_q;
          idx_q   <= idx_q + PTS_W'(1);
          freq_q  <= run_freq_d;
        end
      end
    end
  end

  assign drv.go      = go_q;
  assign drv.control = ctrl_q;
  assign drv.freq    = freq_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign point_idx   = idx_q;

endmodule

// File: tb/tb_ad9833_sweep_ctrl.sv
// Scoreboard bench for ad9833_sweep_ctrl with a behavioural ad9833 handshake model.
// Latency: n/a.
// Backpressure: the driver model sets ack and completion delays per test.
module tb_ad9833_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [27:0] cfg_start_freq;
  logic [27:0] cfg_step;
  logic        cfg_down;
  logic [15:0] cfg_points;
  logic [23:0] cfg_dwell;
  logic [1:0]  cfg_wave;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] point_idx;

  ad9833_sweep_ctrl_if drv_if();

  ad9833_sweep_ctrl #(.DWELL_W(24), .PTS_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cfg_start_freq (cfg_start_freq),
    .cfg_step       (cfg_step),
    .cfg_down       (cfg_down),
    .cfg_points     (cfg_points),
    .cfg_dwell      (cfg_dwell),
    .cfg_wave       (cfg_wave),
    .drv            (drv_if),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .point_idx      (point_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ctrl;
    logic [27:0] freq;
    bit          is_run;
    logic [15:0] idx;
  } exp_frame_t;

  exp_frame_t exp_q[$];
  bit         exp_done_q[$];

  int checks = 0;
  int errors = 0;
  int go_rises = 0;
  int cyc = 0;
  int sc_cyc = 0;
  bit have_sc = 0;
  bit last_run = 0;
  bit gap_chk = 0;
  int exp_dwell = 0;
  int ack_dly = 2;
  int cpl_dly = 34;
  bit same_cyc = 0;
  int idx_nz = 0;
  int base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic push(input logic [15:0] c, input logic [27:0] f, input bit r, input logic [15:0] i);
    exp_frame_t e;
    e.ctrl = c; e.freq = f; e.is_run = r; e.idx = i;
    exp_q.push_back(e);
  endtask

  task automatic cfg(input logic [27:0] f, input logic [27:0] s, input bit dn,
                     input logic [15:0] n, input logic [23:0] d, input logic [1:0] w);
    cfg_start_freq = f; cfg_step = s; cfg_down = dn;
    cfg_points = n; cfg_dwell = d; cfg_wave = w;
  endtask

  // start at cycle T must give go and busy at T+1
  task automatic start_and_check(input string name);
    base = go_rises;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({name, "_go_t1"}, {31'd0, drv_if.go}, 32'd1);
    chk({name, "_busy_t1"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_rises(input int target, input int budget, input string name);
    int n = 0;
    while (go_rises < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (go_rises < target) timeout(name);
  endtask

  task automatic wait_sc(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (drv_if.send_complete !== 1'b1 && n < budget);
    if (drv_if.send_complete !== 1'b1) timeout(name);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    idx_nz = 0;
    do begin
      @(negedge clk);
      n++;
      if (point_idx !== 16'd0) idx_nz++;
    end while (done !== 1'b1 && n < budget);
    if (done !== 1'b1) timeout(name);
    repeat (2) @(negedge clk);
  endtask

  task automatic end_check(input string name);
    chk({name, "_frames_left"}, exp_q.size(), 32'd0);
    chk({name, "_done_left"}, exp_done_q.size(), 32'd0);
    chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Driver model: ack ack_dly cycles after go, complete cpl_dly cycles after the ack
  initial begin
    drv_if.good_to_reset_go = 1'b0;
    drv_if.send_complete    = 1'b0;
    forever begin
      @(negedge clk);
      while (drv_if.go !== 1'b1) @(negedge clk);
      repeat (ack_dly) @(negedge clk);
      drv_if.good_to_reset_go = 1'b1;
      if (same_cyc) drv_if.send_complete = 1'b1;
      @(negedge clk);
      drv_if.good_to_reset_go = 1'b0;
      if (same_cyc) begin
        drv_if.send_complete = 1'b0;
      end else begin
        repeat (cpl_dly - 1) @(negedge clk);
        drv_if.send_complete = 1'b1;
        @(negedge clk);
        drv_if.send_complete = 1'b0;
      end
    end
  end

  // Monitor: pops expected frames on each go rise and expected abort flags on each done
  initial begin : monitor
    exp_frame_t e;
    bit b;
    bit prev_go;
    prev_go = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (drv_if.send_complete === 1'b1) begin
        sc_cyc  = cyc;
        have_sc = 1'b1;
      end
      if (drv_if.go === 1'b1 && !prev_go) begin
        go_rises++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got ctrl 0x%0h freq 0x%0h expected no frame",
                   drv_if.control, drv_if.freq);
        end else begin
          e = exp_q.pop_front();
          chk("frame_ctrl", {16'd0, drv_if.control}, {16'd0, e.ctrl});
          chk("frame_freq", {4'd0, drv_if.freq}, {4'd0, e.freq});
          chk("frame_idx", {16'd0, point_idx}, {16'd0, e.idx});
          if (gap_chk && have_sc)
            chk("go_gap", cyc - sc_cyc, last_run ? exp_dwell + 1 : 1);
          last_run = e.is_run;
        end
        have_sc = 1'b0;
      end
      prev_go = (drv_if.go === 1'b1);
      if (done === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done=1 expected no done");
        end else begin
          b = exp_done_q.pop_front();
          chk("done_aborted", {31'd0, aborted}, {31'd0, b});
        end
        have_sc = 1'b0;
      end
    end
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg(28'd0, 28'd0, 1'b0, 16'd0, 24'd0, 2'd0);
    repeat (3) @(negedge clk);
    chk("rst_go", {31'd0, drv_if.go}, 32'd0);
    chk("rst_control", {16'd0, drv_if.control}, 32'd0);
    chk("rst_freq", {4'd0, drv_if.freq}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_aborted", {31'd0, aborted}, 32'd0);
    chk("rst_idx", {16'd0, point_idx}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Sine sweep with dwell gap checks; mid-sweep start and config changes must be ignored
    ack_dly = 2; cpl_dly = 34; same_cyc = 0;
    cfg(28'h0F00000, 28'h0010000, 1'b0, 16'd3, 24'd5, 2'd0);
    exp_dwell = 5;
    push(16'h2100, 28'h0F00000, 0, 16'd0);
    push(16'h2000, 28'h0F00000, 1, 16'd0);
    push(16'h2000, 28'h0F10000, 1, 16'd1);
    push(16'h2000, 28'h0F20000, 1, 16'd2);
    push(16'h2100, 28'h0F20000, 0, 16'd2);
    exp_done_q.push_back(1'b0);
    gap_chk = 1'b1;
    start_and_check("sine");
    wait_rises(base + 2, 200, "sine_run0");
    repeat (10) @(negedge clk);
    cfg(28'hABCDEF0, 28'h0000001, 1'b1, 16'd7, 24'd1, 2'd1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(2000, "sine_done");
    gap_chk = 1'b0;
    end_check("sine");

    // Down sweep wrapping below zero, square wave
    ack_dly = 1; cpl_dly = 5;
    cfg(28'h0000010, 28'h0000020, 1'b1, 16'd2, 24'd3, 2'd2);
    push(16'h2128, 28'h0000010, 0, 16'd0);
    push(16'h2028, 28'h0000010, 1, 16'd0);
    push(16'h2028, 28'hFFFFFF0, 1, 16'd1);
    push(16'h2128, 28'hFFFFFF0, 0, 16'd1);
    exp_done_q.push_back(1'b0);
    start_and_check("down");
    wait_done(500, "down_done");
    end_check("down");

    // N = 0: only load and mute frames, index never moves
    cfg(28'h0ABCDEF, 28'h0000100, 1'b0, 16'd0, 24'd4, 2'd1);
    push(16'h2102, 28'h0ABCDEF, 0, 16'd0);
    push(16'h2102, 28'h0ABCDEF, 0, 16'd0);
    exp_done_q.push_back(1'b0);
    start_and_check("n0");
    wait_done(500, "n0_done");
    chk("n0_idx_zero", idx_nz, 32'd0);
    end_check("n0");

    // Abort during the first RUN frame's completion wait: no dwell, straight to mute
    ack_dly = 2; cpl_dly = 34;
    cfg(28'h1234567, 28'h0000100, 1'b0, 16'd4, 24'd5, 2'd0);
    push(16'h2100, 28'h1234567, 0, 16'd0);
    push(16'h2000, 28'h1234567, 1, 16'd0);
    push(16'h2100, 28'h1234567, 0, 16'd0);
    exp_done_q.push_back(1'b1);
    start_and_check("abcpl");
    wait_rises(base + 2, 200, "abcpl_run0");
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    wait_sc(200, "abcpl_sc");
    @(negedge clk);
    chk("abcpl_mute_next", {31'd0, drv_if.go}, 32'd1);
    wait_done(500, "abcpl_done");
    end_check("abcpl");

    // Abort in DWELL: mute go the cycle after abort
    cfg(28'h0100000, 28'h0000100, 1'b0, 16'd3, 24'd20, 2'd1);
    push(16'h2102, 28'h0100000, 0, 16'd0);
    push(16'h2002, 28'h0100000, 1, 16'd0);
    push(16'h2102, 28'h0100000, 0, 16'd0);
    exp_done_q.push_back(1'b1);
    start_and_check("abdw");
    wait_rises(base + 2, 200, "abdw_run0");
    wait_sc(200, "abdw_sc");
    repeat (3) @(negedge clk);
    chk("abdw_go_low", {31'd0, drv_if.go}, 32'd0);
    abort = 1'b1;
    @(negedge clk);
    chk("abdw_go_next", {31'd0, drv_if.go}, 32'd1);
    abort = 1'b0;
    wait_done(500, "abdw_done");
    end_check("abdw");

    // Ack and completion in the same cycle
    same_cyc = 1'b1; ack_dly = 2;
    cfg(28'h0200000, 28'h0000400, 1'b0, 16'd2, 24'd2, 2'd0);
    push(16'h2100, 28'h0200000, 0, 16'd0);
    push(16'h2000, 28'h0200000, 1, 16'd0);
    push(16'h2000, 28'h0200400, 1, 16'd1);
    push(16'h2100, 28'h0200400, 0, 16'd1);
    exp_done_q.push_back(1'b0);
    start_and_check("same");
    wait_done(500, "same_done");
    end_check("same");
    same_cyc = 1'b0;

    // Reset during ACK_WAIT, then a full sweep afterwards
    ack_dly = 2; cpl_dly = 34;
    cfg(28'h0300000, 28'h0000010, 1'b0, 16'd2, 24'd3, 2'd0);
    push(16'h2100, 28'h0300000, 0, 16'd0);
    start_and_check("rstmid");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_go", {31'd0, drv_if.go}, 32'd0);
    chk("rstmid_control", {16'd0, drv_if.control}, 32'd0);
    chk("rstmid_freq", {4'd0, drv_if.freq}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_idx", {16'd0, point_idx}, 32'd0);
    repeat (60) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg(28'h0400000, 28'h0000010, 1'b0, 16'd1, 24'd4, 2'd0);
    push(16'h2100, 28'h0400000, 0, 16'd0);
    push(16'h2000, 28'h0400000, 1, 16'd0);
    push(16'h2100, 28'h0400000, 0, 16'd0);
    exp_done_q.push_back(1'b0);
    start_and_check("after");
    wait_done(500, "after_done");
    end_check("after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad9833_sweep_ctrl.md
# ad9833_sweep_ctrl

Frequency-sweep sequencer that drives the existing `ad9833` serial driver through its `go` / `good_to_reset_go` / `send_complete` handshake. Each sweep is a fixed sequence of frames:

- a reset/load frame;
- N run frames stepping the 28-bit frequency word, each held for a programmable dwell;
- a closing mute frame.

It sits between the register/config logic and the `ad9833` instance, and owns that driver's `go`, `control` and `freq` inputs exclusively.

## Interface

Parameters:
- `DWELL_W`, 24, width of the dwell counter in clk cycles
- `PTS_W`, 16, width of the point count and index

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin sweep; sampled only in IDLE
- `abort`  in  1  request early stop; level-sampled while busy
- `cfg_start_freq`  in  28  first frequency word
- `cfg_step`  in  28  per-point increment, unsigned
- `cfg_down`  in  1  1 = subtract step
- `cfg_points`  in  PTS_W  number of run frames N
- `cfg_dwell`  in  DWELL_W  cycles to hold each run point after its `send_complete`
- `cfg_wave`  in  2  0 = sine, 1 = triangle, 2/3 = square
- `go`  out  1  frame request to `ad9833`
- `control`  out  16  control word to `ad9833`
- `freq`  out  28  frequency word to `ad9833`
- `good_to_reset_go`  in  1  driver has latched the request
- `send_complete`  in  1  driver finished shifting the frame
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at sweep end
- `aborted`  out  1  valid with `done`; sweep was cut short
- `point_idx`  out  PTS_W  index of the current run point, 0-based

## Operation

- Wave bits W:
  - sine = 0x2000
  - triangle = 0x2002
  - square = 0x2028
- Frame types:
  - RST = W | 0x0100
  - RUN = W
  - MUTE = W | 0x0100
- Config is latched on the accepted `start`. Changes to config during a sweep are ignored.
- States: IDLE, REQ, ACK_WAIT, CPL_WAIT, DWELL, FINISH.
  - IDLE: on `start` → latch config, freq_acc = start_freq, frame = RST → REQ.
  - REQ: drive `go` = 1 with `control` / `freq` for the current frame → ACK_WAIT.
  - ACK_WAIT: `go` held at 1. On `good_to_reset_go`, `go` = 0 on the next cycle → CPL_WAIT.
  - CPL_WAIT: wait for `send_complete`. Then:
    - after RST: N = 0 → frame MUTE → REQ; otherwise frame RUN, `point_idx` = 0 → REQ.
    - after RUN: → DWELL with counter = `cfg_dwell`.
    - after MUTE: → FINISH.
  - DWELL: decrement to 0. Then:
    - if `point_idx` = N−1 → frame MUTE → REQ;
    - otherwise `point_idx`++, freq_acc ± step → REQ.
  - FINISH: `done` = 1 for one cycle → IDLE.
- Frequency arithmetic: modulo 2^28. Wrap-around is legal and not flagged.
- `control` and `freq` are stable from REQ until `send_complete`.
- Abort:
  - If `abort` is seen in REQ, ACK_WAIT or CPL_WAIT, the in-flight frame is never cut short.
  - After its `send_complete`, the controller goes straight to a MUTE frame. Any remaining RUN frames and the dwell are skipped.
  - `abort` in DWELL ends the dwell immediately → MUTE.
  - `abort` during the MUTE frame itself has no effect.
  - `aborted` = 1 with `done`.
- `start` while busy is ignored.

## Timing

- Reset values:
  - `go` = 0, `control` = 0x0000, `freq` = 0
  - `busy` = 0, `done` = 0, `aborted` = 0, `point_idx` = 0
- Reset mid-sweep returns to IDLE immediately and drops `go`. The driver is not informed.
- `start` high at cycle T → `go` = 1 and `busy` = 1 at T+1.
- `good_to_reset_go` high at cycle A → `go` = 0 at A+1.
- `send_complete` at cycle C:
  - RUN frame: first dwell cycle at C+1.
  - RST or MUTE frame, or `cfg_dwell` = 0: next `go` = 1 at C+1.
- Dwell of D cycles: next `go` at C+1+D.
- `done` is asserted one cycle after the MUTE `send_complete`. `busy` falls in the same cycle.
- `send_complete` or `good_to_reset_go` seen in any state other than the waiting state is ignored.
- `good_to_reset_go` and `send_complete` in the same cycle:
  - the ack is taken, `go` falls, and the completion is honoured;
  - skip CPL_WAIT and advance as if `send_complete` arrived one cycle later.

## Test plan

- Sine sweep:
  - Stimulus: start = 0x0F00000, step = 0x0010000, N = 3, dwell = 5, driver model acks after 2 cycles and completes 34 cycles later.
  - Required response: frames (0x2100, 0x0F00000), (0x2000, 0x0F00000), (0x2000, 0x0F10000), (0x2000, 0x0F20000), (0x2100, 0x0F20000). `done` = 1 once, `aborted` = 0. Gap between `send_complete` and the next `go` is exactly 6 cycles after RUN frames and 1 cycle otherwise.
- Down sweep with wrap:
  - Stimulus: start = 0x0000010, step = 0x20, `cfg_down` = 1, N = 2, square wave.
  - Required response: run freqs 0x0000010, 0xFFFFFF0; control 0x2028 / 0x2128.
- N = 0:
  - Required response: only RST then MUTE frames, then `done`. `point_idx` stays 0.
- Abort during frame 2 CPL_WAIT:
  - Required response: frame 2 completes, no dwell, MUTE is sent, `done` and `aborted` = 1.
  - Abort in DWELL: MUTE `go` appears the cycle after `abort`.
- Handshake edge cases:
  - Ack and complete in the same cycle → no hang, next `go` follows.
  - `start` pulsed while busy → ignored. Changing config mid-sweep does not alter the emitted frames.
- Reset:
  - Stimulus: `rst_n` low during ACK_WAIT.
  - Required response: `go` = 0 asynchronously, all outputs at reset values. A new `start` after release runs a full sweep.
